// File: rtl/sram_port_arbiter.sv
// Round-robin read/write arbiter for one shared dual-port SRAM with write-to-read
// forwarding and a zero-fill CLEAR sequence driven through the write port.
module sram_port_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           rd_valid,
  input  logic [NUM_REQ*DEPTH-1:0]     rd_addr,
  output logic [NUM_REQ-1:0]           rd_ready,
  input  logic [NUM_REQ-1:0]           wr_valid,
  input  logic [NUM_REQ*DEPTH-1:0]     wr_addr,
  input  logic [NUM_REQ*BITWIDTH-1:0]  wr_data,
  input  logic [NUM_REQ*BITWIDTH-1:0]  wr_mask,
  output logic [NUM_REQ-1:0]           wr_ready,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [BITWIDTH-1:0]          rsp_data,
  input  logic                         clr_start,
  output logic                         clr_busy,
  output logic                         clr_done,
  output logic [BITWIDTH-1:0]          sram_d,
  output logic [BITWIDTH-1:0]          sram_bweb,
  output logic                         sram_web,
  output logic [DEPTH-1:0]             sram_aa,
  output logic                         sram_reb,
  output logic [DEPTH-1:0]             sram_ab,
  input  logic [BITWIDTH-1:0]          sram_q,
  output logic                         dbg_state
);

  // Handshake: a request completes in the cycle valid & ready are both high;
  // ready never asserts without valid and responses have no backpressure.
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state;
  logic [ID_W-1:0]     rd_ptr, wr_ptr, rd_sel, wr_sel;
  logic                rd_found, wr_found, rd_gnt, wr_gnt, arb_en;
  logic [DEPTH-1:0]    clr_cnt, rd_a, wr_a;
  logic [BITWIDTH-1:0] wr_d, wr_m;
  logic                fwd_hit;
  logic [BITWIDTH-1:0] fwd_data, fwd_mask;

  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [ID_W-1:0] ptr);
    logic            found;
    logic [ID_W-1:0] sel, cand;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && v[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] s);
    return (s == ID_W'(NUM_REQ - 1)) ? '0 : s + 1'b1;
  endfunction

  // Grants are suppressed while reset is held so the SRAM sees no strobes.
  assign arb_en = (state == IDLE) && !RST;

  always_comb begin
    {rd_found, rd_sel} = rr_pick(rd_valid, rd_ptr);
    {wr_found, wr_sel} = rr_pick(wr_valid, wr_ptr);
  end

  assign rd_gnt = arb_en && rd_found;
  assign wr_gnt = arb_en && wr_found;

  always_comb begin
    rd_a = '0;
    wr_a = '0;
    wr_d = '0;
    wr_m = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_ready[i] = rd_gnt && (rd_sel == ID_W'(i));
      wr_ready[i] = wr_gnt && (wr_sel == ID_W'(i));
      if (rd_sel == ID_W'(i)) rd_a = rd_addr[i*DEPTH +: DEPTH];
      if (wr_sel == ID_W'(i)) begin
        wr_a = wr_addr[i*DEPTH +: DEPTH];
        wr_d = wr_data[i*BITWIDTH +: BITWIDTH];
        wr_m = wr_mask[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  always_comb begin
    sram_web  = wr_gnt;
    sram_aa   = wr_a;
    sram_d    = wr_d;
    sram_bweb = wr_m;
    if (state == CLEAR) begin
      sram_web  = !RST;
      sram_aa   = clr_cnt;
      sram_d    = '0;
      sram_bweb = '1;
    end
  end

  assign sram_reb = rd_gnt;
  assign sram_ab  = rd_a;

  // The SRAM returns pre-write data on a same-address collision; patch it here.
  assign rsp_data  = fwd_hit ? ((fwd_data & fwd_mask) | (sram_q & ~fwd_mask)) : sram_q;
  assign clr_busy  = (state == CLEAR);
  assign dbg_state = (state == CLEAR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      clr_done  <= 1'b0;
      clr_cnt   <= '0;
      fwd_hit   <= 1'b0;
      fwd_data  <= '0;
      fwd_mask  <= '0;
    end else begin
      rsp_valid <= rd_gnt;
      fwd_hit   <= rd_gnt && wr_gnt && (rd_a == wr_a);
      fwd_data  <= wr_d;
      fwd_mask  <= wr_m;
      clr_done  <= 1'b0;
      if (rd_gnt) begin
        rsp_id <= rd_sel;
        rd_ptr <= rr_next(rd_sel);
      end
      if (wr_gnt) wr_ptr <= rr_next(wr_sel);
      case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: behavioural SRAM, a transaction-level
// reference model (round-robin scan, write-first memory view) and directed scenarios.
module tb_sram_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int BW      = 32;
  localparam int DEPTH   = 8;
  localparam int ID_W    = 2;
  localparam int WORDS   = 256;

  logic                    CLK, RST;
  logic [NUM_REQ-1:0]      rd_valid, rd_ready, wr_valid, wr_ready;
  logic [NUM_REQ*DEPTH-1:0] rd_addr, wr_addr;
  logic [NUM_REQ*BW-1:0]   wr_data, wr_mask;
  logic                    rsp_valid, clr_start, clr_busy, clr_done;
  logic [ID_W-1:0]         rsp_id;
  logic [BW-1:0]           rsp_data, sram_d, sram_bweb, sram_q;
  logic                    sram_web, sram_reb, dbg_state;
  logic [DEPTH-1:0]        sram_aa, sram_ab;

  sram_port_arbiter #(.NUM_REQ(NUM_REQ), .BITWIDTH(BW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_ready(wr_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .sram_d(sram_d), .sram_bweb(sram_bweb), .sram_web(sram_web), .sram_aa(sram_aa),
    .sram_reb(sram_reb), .sram_ab(sram_ab), .sram_q(sram_q),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    RST = 1'b1;
  end
  always #5 CLK = ~CLK;

  // behavioural SRAM: registered read of pre-write data, per-bit write enables
  logic [BW-1:0] mem [WORDS];
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      sram_q <= '0;
    end else begin
      if (sram_reb) sram_q <= mem[sram_ab];
      if (sram_web) mem[sram_aa] <= (mem[sram_aa] & ~sram_bweb) | (sram_d & sram_bweb);
    end
  end

  // reference model state
  int                    m_rd_ptr, m_wr_ptr, m_clear_left;
  bit                    m_done_next;
  logic [BW-1:0]         ref_mem [WORDS];
  logic [ID_W+BW-1:0]    exp_q[$];
  logic [NUM_REQ-1:0]    e_rd_ready, e_wr_ready;
  logic                  e_rsp_valid, e_busy, e_done, e_web;
  logic [ID_W-1:0]       e_rsp_id;
  logic [BW-1:0]         e_rsp_data;
  logic [DEPTH-1:0]      e_aa;
  int                    n_checks, n_fail;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (((v >> ((ptr + k) % NUM_REQ)) & NUM_REQ'(1)) != 0) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_rd_ptr = 0; m_wr_ptr = 0; m_clear_left = 0; m_done_next = 0;
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
  endtask

  // Evaluates one cycle from the current inputs; fills e_* and advances the model.
  task automatic model_cycle();
    int ri, wi;
    logic [DEPTH-1:0] a;
    logic [BW-1:0] wd, wm;
    logic [ID_W+BW-1:0] r;
    e_rsp_valid = (exp_q.size() > 0);
    e_rsp_id = '0; e_rsp_data = '0;
    if (e_rsp_valid) begin
      r = exp_q.pop_front();
      e_rsp_id = r[ID_W+BW-1:BW];
      e_rsp_data = r[BW-1:0];
    end
    e_busy = (m_clear_left > 0);
    e_done = m_done_next;
    m_done_next = 0;
    e_rd_ready = '0; e_wr_ready = '0; e_web = 1'b0; e_aa = '0;
    if (m_clear_left > 0) begin
      e_web = 1'b1;
      e_aa = DEPTH'(WORDS - m_clear_left);
      ref_mem[e_aa] = '0;
      m_clear_left--;
      if (m_clear_left == 0) m_done_next = 1;
    end else begin
      ri = rr_pick(rd_valid, m_rd_ptr);
      wi = rr_pick(wr_valid, m_wr_ptr);
      if (wi >= 0) begin
        e_wr_ready = NUM_REQ'(1) << wi;
        e_web = 1'b1;
        e_aa = DEPTH'(wr_addr >> (wi * DEPTH));
        wd = BW'(wr_data >> (wi * BW));
        wm = BW'(wr_mask >> (wi * BW));
        ref_mem[e_aa] = (ref_mem[e_aa] & ~wm) | (wd & wm);
        m_wr_ptr = (wi + 1) % NUM_REQ;
      end
      if (ri >= 0) begin
        e_rd_ready = NUM_REQ'(1) << ri;
        a = DEPTH'(rd_addr >> (ri * DEPTH));
        exp_q.push_back({ID_W'(ri), ref_mem[a]});
        m_rd_ptr = (ri + 1) % NUM_REQ;
      end
      if (clr_start) m_clear_left = WORDS;
    end
  endtask

  task automatic idle_inputs();
    rd_valid = '0; wr_valid = '0; clr_start = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    idle_inputs();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge CLK);
    #1;
    n_checks++;
    if ({rsp_valid, clr_busy, clr_done, sram_web, sram_reb, dbg_state} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp 000000",
               {rsp_valid, clr_busy, clr_done, sram_web, sram_reb, dbg_state});
    end
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_rr_all();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      rd_valid = '1;
      rd_addr = {$urandom, $urandom};
      #1;
      model_cycle();
      n_checks++;
      if (c < 8 && rd_ready !== (NUM_REQ'(1) << (c % NUM_REQ))) begin
        n_fail++; $display("FAIL rr_all_grant c=%0d got %b exp %b", c, rd_ready, NUM_REQ'(1) << (c % NUM_REQ));
      end
      n_checks++;
      if (rsp_valid !== (c > 0) || (c > 0 && rsp_id !== ID_W'((c - 1) % NUM_REQ))) begin
        n_fail++; $display("FAIL rr_all_rsp c=%0d got v=%b id=%0d exp v=%b id=%0d", c, rsp_valid, rsp_id, c > 0, (c + 3) % NUM_REQ);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [NUM_REQ-1:0] exp_g [3];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      rd_valid = 4'b1010;
      #1;
      model_cycle();
      n_checks++;
      if (rd_ready !== exp_g[c]) begin
        n_fail++; $display("FAIL rr_sparse c=%0d got %b exp %b", c, rd_ready, exp_g[c]);
      end
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    model_cycle();
  endtask

  task automatic test_write_read();
    do_reset();
    @(negedge CLK);
    wr_valid = 4'b0001; wr_addr[7:0] = 8'h10; wr_data[31:0] = 32'hFFFF0000; wr_mask[31:0] = '1;
    #1; model_cycle();
    n_checks++;
    if (wr_ready !== 4'b0001 || sram_web !== 1'b1 || sram_aa !== 8'h10 || sram_d !== 32'hFFFF0000) begin
      n_fail++; $display("FAIL wr_port got rdy=%b web=%b aa=%h d=%h exp 0001 1 10 ffff0000", wr_ready, sram_web, sram_aa, sram_d);
    end
    @(negedge CLK);
    wr_valid = '0; rd_valid = 4'b0100; rd_addr[23:16] = 8'h10;
    #1; model_cycle();
    @(negedge CLK);
    rd_valid = '0;
    #1; model_cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'hFFFF0000) begin
      n_fail++; $display("FAIL write_read got v=%b id=%0d d=%h exp 1 2 ffff0000", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_forward();
    @(negedge CLK);
    wr_valid = 4'b0010; wr_addr[15:8] = 8'h10; wr_data[63:32] = 32'h12345678; wr_mask[63:32] = '1;
    #1; model_cycle();
    @(negedge CLK);
    wr_data[63:32] = 32'hAAAAAAAA; wr_mask[63:32] = 32'h0000FFFF;
    rd_valid = 4'b0010; rd_addr[15:8] = 8'h10;
    #1; model_cycle();
    n_checks++;
    if (sram_reb !== 1'b1 || sram_ab !== sram_aa || sram_bweb !== 32'h0000FFFF) begin
      n_fail++; $display("FAIL fwd_collide got reb=%b ab=%h aa=%h bweb=%h exp 1 10 10 0000ffff", sram_reb, sram_ab, sram_aa, sram_bweb);
    end
    @(negedge CLK);
    wr_valid = '0;
    #1; model_cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234AAAA) begin
      n_fail++; $display("FAIL fwd_data got v=%b d=%h exp 1 1234aaaa", rsp_valid, rsp_data);
    end
    @(negedge CLK);
    rd_valid = '0;
    #1; model_cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234AAAA) begin
      n_fail++; $display("FAIL fwd_followup got v=%b d=%h exp 1 1234aaaa", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_clear();
    int dones;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      @(negedge CLK);
      wr_valid = 4'b0001; wr_addr[7:0] = 8'(a); wr_data[31:0] = $urandom | 32'h1; wr_mask[31:0] = '1;
      #1; model_cycle();
    end
    @(negedge CLK);
    rd_valid = '1; wr_valid = '1; clr_start = 1'b1;
    wr_mask = {NUM_REQ*BW{1'b1}}; wr_data = {$urandom, $urandom, $urandom, $urandom};
    #1; model_cycle();
    dones = 0;
    for (int c = 0; c < WORDS; c++) begin
      @(negedge CLK);
      clr_start = (c == 10);
      #1; model_cycle();
      if (clr_done === 1'b1) dones++;
      n_checks++;
      if (rd_ready !== 4'b0 || wr_ready !== 4'b0 || clr_busy !== 1'b1 || sram_web !== 1'b1 ||
          sram_aa !== 8'(c) || sram_bweb !== '1 || sram_d !== '0) begin
        n_fail++; $display("FAIL clear_cycle c=%0d rdy=%b/%b busy=%b web=%b aa=%h", c, rd_ready, wr_ready, clr_busy, sram_web, sram_aa);
      end
      n_checks++;
      if (rsp_valid !== e_rsp_valid || (e_rsp_valid && rsp_id !== e_rsp_id)) begin
        n_fail++; $display("FAIL clear_rsp c=%0d got v=%b id=%0d exp v=%b id=%0d", c, rsp_valid, rsp_id, e_rsp_valid, e_rsp_id);
      end
    end
    @(negedge CLK);
    wr_valid = '0; rd_valid = 4'b0001; rd_addr[7:0] = 8'h0; clr_start = 1'b0;
    #1; model_cycle();
    if (clr_done === 1'b1) dones++;
    n_checks++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0 || rd_ready !== 4'b0001) begin
      n_fail++; $display("FAIL clear_exit got done=%b busy=%b rdy=%b exp 1 0 0001", clr_done, clr_busy, rd_ready);
    end
    for (int a = 1; a < 5; a++) begin
      @(negedge CLK);
      rd_valid = (a < 4) ? 4'b0001 : 4'b0000; rd_addr[7:0] = 8'(a);
      #1; model_cycle();
      if (clr_done === 1'b1) dones++;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
        n_fail++; $display("FAIL clear_readback a=%0d got v=%b d=%h exp 1 00000000", a - 1, rsp_valid, rsp_data);
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL clear_done_pulses got %0d exp 1", dones);
    end
  endtask

  task automatic test_reset_mid_clear();
    @(negedge CLK);
    wr_valid = 4'b0001; wr_addr[7:0] = 8'h20; wr_data[31:0] = 32'hDEADBEEF; wr_mask[31:0] = '1;
    rd_valid = 4'b0010; clr_start = 1'b1;
    #1; model_cycle();
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      wr_valid = '0; clr_start = 1'b0; rd_valid = '1;
      #1; model_cycle();
    end
    n_checks++;
    if (clr_busy !== 1'b1 || dbg_state !== 1'b1) begin
      n_fail++; $display("FAIL mid_clear_busy got busy=%b st=%b exp 1 1", clr_busy, dbg_state);
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || clr_busy !== 1'b0 || sram_web !== 1'b0 || dbg_state !== 1'b0) begin
      n_fail++; $display("FAIL mid_clear_reset got v=%b busy=%b web=%b st=%b exp 0 0 0 0", rsp_valid, clr_busy, sram_web, dbg_state);
    end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    idle_inputs();
    @(negedge CLK);
    rd_valid = '1; wr_valid = '1; rd_addr = '0; rd_addr[7:0] = 8'h20; wr_addr = '0; wr_addr[7:0] = 8'h40; wr_mask = '1;
    #1; model_cycle();
    n_checks++;
    if (rd_ready !== 4'b0001 || wr_ready !== 4'b0001 || clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_ptr got rd=%b wr=%b busy=%b exp 0001 0001 0", rd_ready, wr_ready, clr_busy);
    end
    @(negedge CLK);
    idle_inputs();
    #1; model_cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_mem got v=%b d=%h exp 1 00000000", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 700; c++) begin
      @(negedge CLK);
      rd_valid = 4'($urandom_range(0, 15));
      wr_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_addr[i*DEPTH +: DEPTH] = 8'($urandom_range(0, 7));
        wr_addr[i*DEPTH +: DEPTH] = 8'($urandom_range(0, 7));
        wr_data[i*BW +: BW] = $urandom;
        wr_mask[i*BW +: BW] = $urandom;
      end
      clr_start = ($urandom_range(0, 249) == 0);
      #1; model_cycle();
      n_checks++;
      if (rd_ready !== e_rd_ready || wr_ready !== e_wr_ready) begin
        n_fail++; $display("FAIL rand_grant c=%0d got %b/%b exp %b/%b", c, rd_ready, wr_ready, e_rd_ready, e_wr_ready);
      end
      n_checks++;
      if (rsp_valid !== e_rsp_valid || (e_rsp_valid && (rsp_id !== e_rsp_id || rsp_data !== e_rsp_data))) begin
        n_fail++; $display("FAIL rand_rsp c=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                           c, rsp_valid, rsp_id, rsp_data, e_rsp_valid, e_rsp_id, e_rsp_data);
      end
      n_checks++;
      if (clr_busy !== e_busy || clr_done !== e_done || sram_web !== e_web || (e_web && sram_aa !== e_aa)) begin
        n_fail++; $display("FAIL rand_ctl c=%0d got busy=%b done=%b web=%b aa=%h exp %b %b %b %h",
                           c, clr_busy, clr_done, sram_web, sram_aa, e_busy, e_done, e_web, e_aa);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_rr_all();
    test_rr_sparse();
    test_write_read();
    test_forward();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Round-robin arbiter and sequencer for one dual-port SRAM instance (one write port, one registered read port) shared by NUM_REQ requesters.
- Grants at most one read and one write per cycle.
- Returns read data with the requester ID at fixed 1-cycle latency.
- Forwards same-cycle write data to a colliding read.
- Provides a CLEAR sequence that zero-fills the array through the write port.
- Sits between the SM-side load/store requesters and the shared scratch SRAM.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
BITWIDTH, 32, data width; write mask is per bit
DEPTH, 8, address width; array has 2**DEPTH entries
ID_W, $clog2(NUM_REQ), requester ID width (derived)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
rd_valid  in  NUM_REQ  per-requester read request
rd_addr  in  NUM_REQ*DEPTH  packed read addresses; requester i at [i*DEPTH +: DEPTH]
rd_ready  out  NUM_REQ  read grant, one-hot or zero
wr_valid  in  NUM_REQ  per-requester write request
wr_addr  in  NUM_REQ*DEPTH  packed write addresses
wr_data  in  NUM_REQ*BITWIDTH  packed write data
wr_mask  in  NUM_REQ*BITWIDTH  packed bit-enables; 1 = write the bit
wr_ready  out  NUM_REQ  write grant, one-hot or zero
rsp_valid  out  1  read response valid
rsp_id  out  ID_W  requester index of the response
rsp_data  out  BITWIDTH  read data after forwarding
clr_start  in  1  start a zero-fill pulse; ignored unless IDLE
clr_busy  out  1  high while in CLEAR
clr_done  out  1  one-cycle pulse after the last clear write
sram_d  out  BITWIDTH  to SRAM D
sram_bweb  out  BITWIDTH  to SRAM BWEB
sram_web  out  1  to SRAM WEB (1 = write)
sram_aa  out  DEPTH  to SRAM AA (write address)
sram_reb  out  1  to SRAM REB (1 = read)
sram_ab  out  DEPTH  to SRAM AB (read address)
sram_q  in  BITWIDTH  from SRAM Q; valid the cycle after sram_reb

Behaviour:
Reset (RST high, asynchronous):
- FSM to IDLE.
- Both round-robin pointers to 0.
- rsp_valid, rsp_id, clr_busy, clr_done, sram_web, sram_reb to 0.
- Forwarding register and clear counter to 0.
- Any in-flight response is dropped.
- The parent drives the SRAM RSTN from ~RST.

FSM states:
- IDLE -> CLEAR on clr_start.
- CLEAR -> IDLE after writing address 2**DEPTH-1.
- clr_start while in CLEAR is ignored.

IDLE arbitration (combinational grants, registered state):
- Read and write use independent round-robin arbiters.
- Search starts at the pointer and takes the lowest index i >= ptr, wrapping, with valid[i]=1.
- On a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant the pointer holds.
- rd_ready[i]/wr_ready[i] assert only when the corresponding valid is high. A request completes in the cycle valid&ready=1.
- A requester may hold a read and a write grant in the same cycle.

Write grant to i:
- sram_web=1, sram_aa=wr_addr[i], sram_d=wr_data[i], sram_bweb=wr_mask[i], all in the same cycle.
- sram_web=0 when there is no grant; the other SRAM outputs are don't-care.

Read grant to j:
- sram_reb=1, sram_ab=rd_addr[j] in the same cycle.
- Next cycle: rsp_valid=1, rsp_id=j.
- No backpressure on responses; back-to-back reads produce back-to-back responses.

Read/write collision forwarding:
- Applies when a read and a write are granted in the same cycle with sram_ab==sram_aa.
- Because the SRAM returns old data, the block registers fwd_hit=1, fwd_data=write data and fwd_mask=write mask.
- Next cycle: rsp_data = (fwd_data & fwd_mask) | (sram_q & ~fwd_mask).
- Otherwise rsp_data = sram_q.

CLEAR:
- All rd_ready and wr_ready are 0.
- Each cycle: sram_web=1, sram_bweb=all ones, sram_d=0, sram_aa=counter. The counter runs 0..2**DEPTH-1, one write per cycle, so CLEAR lasts 2**DEPTH cycles.
- clr_busy=1 throughout.
- clr_done pulses in the first IDLE cycle after CLEAR. Arbitration resumes that cycle with the pointers unchanged.
- A read response issued in the cycle clr_start is accepted still completes normally in the next cycle.
- Reset during CLEAR aborts it; the SRAM is also reset-cleared.

Test Plan:
- Reset, then all 4 rd_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_id follows one cycle later; rsp_valid=1 continuously from cycle 1.
- rd_valid=4'b1010 with pointer=0 -> grant 1 then 3 then 1; pointer values 2, 0, 2.
- Write addr 0x10 data 0xFFFF0000 mask all-ones; next cycle read 0x10 -> rsp_data=0xFFFF0000 one cycle after the read grant.
- Array word 0x10=0x12345678. Same-cycle write 0x10 data 0xAAAAAAAA mask 0x0000FFFF, read 0x10 -> rsp_data=0x1234AAAA; a following read -> 0x1234AAAA.
- Fill addresses 0..3, pulse clr_start with rd_valid/wr_valid high:
  - no grants for 256 cycles;
  - clr_busy=1 for those 256 cycles;
  - clr_done pulses once;
  - reads of 0..3 then return 0.
- Assert RST mid-CLEAR (cycle 100) with a response pending -> rsp_valid=0, clr_busy=0 immediately; after release, FSM is IDLE and pointers restart at 0.
